sha_block_loader: RTL and testbench
===================================

SHA_BLOCK_LOADER -- requirements
Module: sha_block_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 16: words per message block.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-003 SHALL have port n_rst  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port word_in  input  32: incoming message word.
REQ-005 SHALL have port word_valid  input  1: word_in holds a valid word.
REQ-006 SHALL have port word_ready  output  1: loader accepts word_in this cycle.
REQ-007 SHALL have port flush  input  1: synchronous abort of the current block.
REQ-008 SHALL have port core_done  input  1: one-cycle pulse from the SHA core at end of compression.
REQ-009 SHALL have port shift_enable  output  1: drives the shift_enable of the 16-word shift register.
REQ-010 SHALL have port serial_out  output  32: drives the serial_in of the shift register.
REQ-011 SHALL have port core_start  output  1: one-cycle pulse, parallel block valid for the core.
REQ-012 SHALL have port busy  output  1: high in START and BUSY states.
REQ-013 SHALL have port word_count  output  5: words accepted into the current block (0..NUM_WORDS-1).
REQ-014 SHALL have port block_count  output  8: completed blocks, wraps 255->0.

Function
REQ-015 SHALL implement FSM states LOAD, START, BUSY.
REQ-016 In LOAD, word_ready SHALL be 1 unless flush=1; in START and BUSY word_ready SHALL be 0.
REQ-017 A word SHALL be accepted in a cycle where word_valid=1 and word_ready=1.
REQ-018 shift_enable SHALL be combinationally 1 exactly in accept cycles; serial_out SHALL equal word_in combinationally.
REQ-019 Each accept SHALL increment word_count by 1 at the next edge.
REQ-020 An accept with word_count=NUM_WORDS-1 SHALL clear word_count to 0 and move LOAD->START at the next edge.
REQ-021 START SHALL last exactly one cycle with core_start=1 (registered, state-decoded), then move to BUSY.
REQ-022 Latency: the 16th word accepted in cycle N SHALL give core_start=1 in cycle N+1, when the shift register already holds all 16 words.
REQ-023 BUSY SHALL hold until core_done=1; then BUSY->LOAD at the next edge, with block_count incremented.
REQ-024 core_done SHALL be ignored in LOAD and START.
REQ-025 No shift SHALL occur outside LOAD, so the shift register stays stable while the core reads it.
REQ-026 When flush=1 in any state, the next state SHALL be LOAD and word_count SHALL become 0.
REQ-027 While flush=1, no word SHALL be accepted and block_count SHALL be unchanged.
REQ-028 flush SHALL win over a simultaneous accept, START entry or core_done.
REQ-029 flush=1 in START SHALL abort the block: core_start is still 1 that cycle, and the next state is LOAD, not BUSY.
REQ-030 word_valid low mid-block SHALL hold word_count; there is no timeout.

Reset
REQ-031 On n_rst=0, the FSM SHALL asynchronously enter LOAD.
REQ-032 On n_rst=0, word_count and block_count SHALL become 0.
REQ-033 On n_rst=0, core_start SHALL become 0; word_ready follows state LOAD (1 unless flush=1).
REQ-034 Reset asserted mid-block or in BUSY SHALL discard the partial block; the first 16 accepts after release form a new block.

Verification
REQ-035 16 back-to-back words 0x00000001..0x00000010 with word_valid=1 -> 16 shift_enable cycles, core_start pulse one cycle after the 16th, word_ready=0, busy=1.
REQ-036 In BUSY, word_valid=1 for 10 cycles -> no shift_enable; core_done pulse -> LOAD next cycle, block_count=1, word_ready=1.
REQ-037 word_valid toggling 1/0 for 32 cycles -> word_count steps 0..15, core_start after the 16th accept only.
REQ-038 flush=1 after 7 accepts, with word_valid=1 the same cycle -> that word is not accepted, word_count=0, then 16 more words are needed for core_start.
REQ-039 n_rst=0 pulse in BUSY -> immediate LOAD, counts 0; a core_done arriving after release is ignored.
REQ-040 256 full blocks, each with core_done -> block_count wraps to 0.

Source files
------------

// File: rtl/sha_block_loader.sv
// Streams message words into the external 16-word shift register, then hands the
// completed block to the SHA core and holds the register stable until the core is done.
module sha_block_loader #(
    parameter int NUM_WORDS = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        flush,
    input  logic        core_done,
    output logic        shift_enable,
    output logic [31:0] serial_out,
    output logic        core_start,
    output logic        busy,
    output logic [4:0]  word_count,
    output logic [7:0]  block_count,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_WORD = 5'(NUM_WORDS - 1);

    state_t      r_state, w_next_state;
    logic [4:0]  r_word_count, w_next_word_count;
    logic [7:0]  r_block_count, w_next_block_count;
    logic        w_accept;

    // Handshake: a word transfers in any cycle where word_valid and word_ready are both
    // high; word_ready does not depend on word_valid, and flush blocks the transfer.
    assign word_ready   = (r_state == LOAD) && !flush;
    assign w_accept     = word_valid && word_ready;
    assign shift_enable = w_accept;
    assign serial_out   = word_in;
    assign core_start   = (r_state == START);
    assign busy         = (r_state != LOAD);
    assign word_count   = r_word_count;
    assign block_count  = r_block_count;
    assign o_dbg_state  = r_state;

    always_comb begin
        w_next_state       = r_state;
        w_next_word_count  = r_word_count;
        w_next_block_count = r_block_count;
        if (flush) begin
            w_next_state      = LOAD;
            w_next_word_count = 5'd0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        if (r_word_count == LAST_WORD) begin
                            w_next_state      = START;
                            w_next_word_count = 5'd0;
                        end else begin
                            w_next_word_count = r_word_count + 5'd1;
                        end
                    end
                end
                START: w_next_state = BUSY;
                BUSY: begin
                    if (core_done) begin
                        w_next_state       = LOAD;
                        w_next_block_count = r_block_count + 8'd1;
                    end
                end
                default: w_next_state = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= LOAD;
            r_word_count  <= 5'd0;
            r_block_count <= 8'd0;
        end else begin
            r_state       <= w_next_state;
            r_word_count  <= w_next_word_count;
            r_block_count <= w_next_block_count;
        end
    end

endmodule

// File: tb/tb_sha_block_loader.sv
// Directed bench for sha_block_loader: every cycle is checked against a small reference
// model, and each delivered block is compared word by word with what was sent.
module tb_sha_block_loader;

    logic        clk;
    logic        n_rst;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        flush;
    logic        core_done;
    logic        shift_enable;
    logic [31:0] serial_out;
    logic        core_start;
    logic        busy;
    logic [4:0]  word_count;
    logic [7:0]  block_count;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    int          m_state;
    int          m_wc;
    int          m_bc;
    logic [31:0] exp_q[$];
    logic [31:0] act_q[$];

    sha_block_loader #(.NUM_WORDS(16)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .flush        (flush),
        .core_done    (core_done),
        .shift_enable (shift_enable),
        .serial_out   (serial_out),
        .core_start   (core_start),
        .busy         (busy),
        .word_count   (word_count),
        .block_count  (block_count),
        .o_dbg_state  (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check the model, advance the model.
    task automatic step(input logic v, input logic [31:0] w, input logic f, input logic d);
        logic exp_ready;
        logic exp_acc;
        @(negedge clk);
        word_valid = v;
        word_in    = w;
        flush      = f;
        core_done  = d;
        #1;
        exp_ready = (m_state == 0) && !f;
        exp_acc   = v && exp_ready;
        chk("word_ready",   32'(word_ready),   32'(exp_ready));
        chk("shift_enable", 32'(shift_enable), 32'(exp_acc));
        chk("serial_out",   serial_out,        w);
        chk("core_start",   32'(core_start),   32'(m_state == 1));
        chk("busy",         32'(busy),         32'(m_state != 0));
        chk("word_count",   32'(word_count),   32'(m_wc));
        chk("block_count",  32'(block_count),  32'(m_bc[7:0]));
        chk("state",        32'(o_dbg_state),  32'(m_state));
        if (shift_enable) begin
            act_q.push_back(serial_out);
            if (act_q.size() > 16) void'(act_q.pop_front());
        end
        if (m_state == 1) begin
            chk("block_size", 32'(exp_q.size()), 32'd16);
            if (exp_q.size() == 16 && act_q.size() == 16) begin
                for (int i = 0; i < 16; i++) chk("block_word", act_q[i], exp_q[i]);
            end
            exp_q.delete();
        end
        if (f) begin
            m_state = 0;
            m_wc    = 0;
            exp_q.delete();
        end else begin
            case (m_state)
                0: if (exp_acc) begin
                    exp_q.push_back(w);
                    if (m_wc == 15) begin
                        m_state = 1;
                        m_wc    = 0;
                    end else begin
                        m_wc++;
                    end
                end
                1: m_state = 2;
                default: if (d) begin
                    m_state = 0;
                    m_bc    = (m_bc + 1) % 256;
                end
            endcase
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic load_block(input logic [31:0] base);
        for (int i = 0; i < 16; i++) step(1'b1, base + 32'(i), 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        #2 n_rst = 1'b0;
        #1;
        chk("rst_state",      32'(o_dbg_state), 32'd0);
        chk("rst_word_count", 32'(word_count),  32'd0);
        chk("rst_block_cnt",  32'(block_count), 32'd0);
        chk("rst_core_start", 32'(core_start),  32'd0);
        chk("rst_ready",      32'(word_ready),  32'(!flush));
        m_state = 0;
        m_wc    = 0;
        m_bc    = 0;
        exp_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst      = 1'b1;
        word_in    = 32'h0;
        word_valid = 1'b0;
        flush      = 1'b0;
        core_done  = 1'b0;
        m_state    = 0;
        m_wc       = 0;
        m_bc       = 0;
        reset_pulse();

        // 16 back-to-back words, then BUSY ignores valid words until core_done
        load_block(32'h1);
        #1 chk("start_after_16", 32'(core_start), 32'd1);
        idle();
        for (int i = 0; i < 10; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        #1 chk("bc_after_first", 32'(block_count), 32'd1);
        chk("ready_after_first", 32'(word_ready), 32'd1);

        // Toggling valid: one accept every other cycle
        for (int i = 0; i < 32; i++) step(i % 2 == 0, 32'h100 + 32'(i), 1'b0, 1'b0);
        idle();
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // core_done in LOAD has no effect
        step(1'b0, 32'h0, 1'b0, 1'b1);
        #1 chk("done_in_load_bc", 32'(block_count), 32'd2);

        // Flush after 7 accepts, then a fresh 16 are needed; flush again in START
        for (int i = 0; i < 7; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h2FF, 1'b1, 1'b0);
        #1 chk("wc_after_flush", 32'(word_count), 32'd0);
        load_block(32'h300);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        #1 chk("flush_in_start", 32'(o_dbg_state), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        #1 chk("bc_after_abort", 32'(block_count), 32'd2);

        // Reset in BUSY; a later core_done is ignored
        load_block(32'h400);
        idle();
        idle();
        reset_pulse();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        #1 chk("bc_after_reset", 32'(block_count), 32'd0);

        // 256 full blocks wrap block_count
        for (int b = 0; b < 256; b++) begin
            load_block(32'(b) << 8);
            idle();
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (b == 254) begin
                #1 chk("bc_255", 32'(block_count), 32'd255);
            end
        end
        #1 chk("bc_wrap", 32'(block_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
